idt: RTL and testbench

- Registered RV32I instruction-format classifier. Maps the 7-bit major opcode to a one-hot format flag: R, I, S, B, U or J.
- Sits beside the instruction decoder. The decoder uses the flags as AND-masks to assemble imm12/imm20, so flags must be all-zero for any unsupported opcode.
- Also reports an illegal-opcode flag, an encoded format code, and a valid qualifier.

---
 rtl/idt_pkg.sv | 53 +++++
 rtl/idt_dec.sv | 59 +++++
 rtl/idt.sv | 143 ++++++++++++++
 tb/tb_idt.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/idt_pkg.sv
// -----------------------------------------------------------------------------
// idt_pkg
// Shared definitions for the RV32I instruction-format classifier (idt) and
// its combinational decode core (idt_dec).
//
// Contents:
//   - RV32I major opcode constants (instruction bits [6:0]).
//   - fmt_e        : encoded instruction format (0 none .. 6 J).
//   - fmt_flags_t  : packed one-hot format flags {r, i, s, b, u, j}.
//   - flags_none() : true when no format flag is set.
// -----------------------------------------------------------------------------
package idt_pkg;

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Encoded format; FMT_NONE doubles as the "illegal" class index.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    // One-hot (or all-zero) format flags.
    typedef struct packed {
        logic r;
        logic i;
        logic s;
        logic b;
        logic u;
        logic j;
    } fmt_flags_t;

    // True when the opcode matched no supported format.
    function automatic logic flags_none(input fmt_flags_t f);
        return ~|f;
    endfunction

endpackage : idt_pkg

// File: rtl/idt_dec.sv
// -----------------------------------------------------------------------------
// idt_dec
// Purely combinational RV32I opcode -> instruction-format decode.
// Shared by the registered classifier (idt) and by the instruction decoder's
// combinational paths. Unsupported opcodes, including any with bits [1:0]
// other than 2'b11, yield all-zero flags and FMT_NONE, so the flags are safe
// to use directly as AND-masks when assembling immediates.
//
// Ports:
//   opcode : input  [6:0]  instruction bits [6:0]
//   flags  : output        one-hot {r,i,s,b,u,j}, all-zero when unsupported
//   fmt    : output [2:0]  encoded format (fmt_e)
// -----------------------------------------------------------------------------
module idt_dec
    import idt_pkg::*;
(
    input  logic [6:0] opcode,
    output fmt_flags_t flags,
    output fmt_e       fmt
);

    always_comb begin
        flags = '0;
        fmt   = FMT_NONE;
        // Full 7-bit match: compressed/reserved encodings (bits [1:0] != 11)
        // fall through to the default and stay all-zero.
        case (opcode)
            OP_R: begin
                flags.r = 1'b1;
                fmt     = FMT_R;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                flags.i = 1'b1;
                fmt     = FMT_I;
            end
            OP_STORE: begin
                flags.s = 1'b1;
                fmt     = FMT_S;
            end
            OP_BRANCH: begin
                flags.b = 1'b1;
                fmt     = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                flags.u = 1'b1;
                fmt     = FMT_U;
            end
            OP_JAL: begin
                flags.j = 1'b1;
                fmt     = FMT_J;
            end
            default: begin
                flags = '0;
                fmt   = FMT_NONE;
            end
        endcase
    end

endmodule : idt_dec

// File: rtl/idt.sv
// -----------------------------------------------------------------------------
// idt
// Registered RV32I instruction-format classifier. One opcode accepted per
// cycle, results appear one cycle later. Outputs are cleared (not held) on
// any cycle without in_valid so downstream masking never sees stale flags.
//
// Optional build macro: IDT_STATS_EN
//   When defined, adds parameter CNT_W, input stats_clr and seven saturating
//   per-class counters cnt_r/i/s/b/u/j/ill. When undefined those do not exist
//   and classification is unchanged.
//
// Ports:
//   clk        : input         rising-edge clock
//   rst        : input         synchronous active-high reset (overrides in_valid)
//   in_valid   : input         opcode valid this cycle
//   opcode     : input  [6:0]  instruction bits [6:0]
//   out_valid  : output        registered in_valid
//   R,I,S,B,U,J: output        registered one-hot format flags
//   illegal    : output        valid opcode with no matching format
//   fmt        : output [2:0]  encoded format (0 none, 1 R .. 6 J)
//   stats_clr  : input         clear counters           (IDT_STATS_EN)
//   cnt_*      : output [CNT_W-1:0] per-class counts    (IDT_STATS_EN)
// -----------------------------------------------------------------------------
module idt
    import idt_pkg::*;
`ifdef IDT_STATS_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [6:0]       opcode,
    output logic             out_valid,
    output logic             R,
    output logic             I,
    output logic             S,
    output logic             B,
    output logic             U,
    output logic             J,
    output logic             illegal,
    output logic [2:0]       fmt
`ifdef IDT_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt_r,
    output logic [CNT_W-1:0] cnt_i,
    output logic [CNT_W-1:0] cnt_s,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_u,
    output logic [CNT_W-1:0] cnt_j,
    output logic [CNT_W-1:0] cnt_ill
`endif
);

    // ---- stage p0: combinational decode of the incoming opcode ----
    fmt_flags_t flags_p0;
    fmt_e       fmt_p0;

    idt_dec u_dec (
        .opcode (opcode),
        .flags  (flags_p0),
        .fmt    (fmt_p0)
    );

    // ---- stage p1: registered results ----
    logic       vld_p1;
    fmt_flags_t flags_p1;
    fmt_e       fmt_p1;
    logic       ill_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            flags_p1 <= '0;
            fmt_p1   <= FMT_NONE;
            ill_p1   <= 1'b0;
        end else if (in_valid) begin
            vld_p1   <= 1'b1;
            flags_p1 <= flags_p0;
            fmt_p1   <= fmt_p0;
            ill_p1   <= flags_none(flags_p0);
        end else begin
            // Idle cycle: drop everything so masks never carry stale data.
            vld_p1   <= 1'b0;
            flags_p1 <= '0;
            fmt_p1   <= FMT_NONE;
            ill_p1   <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign R         = flags_p1.r;
    assign I         = flags_p1.i;
    assign S         = flags_p1.s;
    assign B         = flags_p1.b;
    assign U         = flags_p1.u;
    assign J         = flags_p1.j;
    assign illegal   = ill_p1;
    assign fmt       = fmt_p1;

`ifdef IDT_STATS_EN
    // Counter array indexed by fmt_e: slot 0 (FMT_NONE) is the illegal count.
    localparam int NCLS = 7;

    logic [CNT_W-1:0] cnt_p1 [NCLS];

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return (&v) ? v : v + one;
    endfunction

    // ---- stage p1: statistics, updated on the same edge as the flags ----
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            // Clear wins over a same-cycle increment.
            for (int k = 0; k < NCLS; k++) begin
                cnt_p1[k] <= '0;
            end
        end else if (in_valid) begin
            for (int k = 0; k < NCLS; k++) begin
                if (int'(fmt_p0) == k) begin
                    cnt_p1[k] <= sat_inc(cnt_p1[k]);
                end
            end
        end
    end

    assign cnt_ill = cnt_p1[int'(FMT_NONE)];
    assign cnt_r   = cnt_p1[int'(FMT_R)];
    assign cnt_i   = cnt_p1[int'(FMT_I)];
    assign cnt_s   = cnt_p1[int'(FMT_S)];
    assign cnt_b   = cnt_p1[int'(FMT_B)];
    assign cnt_u   = cnt_p1[int'(FMT_U)];
    assign cnt_j   = cnt_p1[int'(FMT_J)];
`endif

endmodule : idt

// File: tb/tb_idt.sv
// -----------------------------------------------------------------------------
// tb_idt
// Self-checking bench for idt. Each driven cycle pushes its expected output
// (from an independent opcode table) into a scoreboard queue; one cycle later
// the entry is popped and compared against the registered outputs.
// With IDT_STATS_EN defined, the counters are checked too (CNT_W = 4 so that
// saturation is reachable quickly).
// -----------------------------------------------------------------------------
module tb_idt;

`ifdef IDT_STATS_EN
    localparam int CW = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] opcode;
    logic       out_valid, R, I, S, B, U, J, illegal;
    logic [2:0] fmt;
`ifdef IDT_STATS_EN
    logic          stats_clr;
    logic [CW-1:0] cnt_r, cnt_i, cnt_s, cnt_b, cnt_u, cnt_j, cnt_ill;
`endif

    always #5 clk = ~clk;

`ifdef IDT_STATS_EN
    idt #(.CNT_W(CW)) dut (
`else
    idt dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .out_valid (out_valid),
        .R         (R),
        .I         (I),
        .S         (S),
        .B         (B),
        .U         (U),
        .J         (J),
        .illegal   (illegal),
        .fmt       (fmt)
`ifdef IDT_STATS_EN
        ,
        .stats_clr (stats_clr),
        .cnt_r     (cnt_r),
        .cnt_i     (cnt_i),
        .cnt_s     (cnt_s),
        .cnt_b     (cnt_b),
        .cnt_u     (cnt_u),
        .cnt_j     (cnt_j),
        .cnt_ill   (cnt_ill)
`endif
    );

    // Expected output word: {vld, R,I,S,B,U,J, illegal, fmt}
    typedef struct packed {
        logic       vld;
        logic [5:0] fl;
        logic       ill;
        logic [2:0] fmt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference table written directly from the opcode map.
    function automatic exp_t model(input logic v, input logic [6:0] op);
        exp_t e;
        e = '0;
        if (!v) return e;
        e.vld = 1'b1;
        if (op == 7'b0110011) begin
            e.fl = 6'b100000; e.fmt = 3'd1;
        end else if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111 ||
                     op == 7'b1110011 || op == 7'b0001111) begin
            e.fl = 6'b010000; e.fmt = 3'd2;
        end else if (op == 7'b0100011) begin
            e.fl = 6'b001000; e.fmt = 3'd3;
        end else if (op == 7'b1100011) begin
            e.fl = 6'b000100; e.fmt = 3'd4;
        end else if (op == 7'b0110111 || op == 7'b0010111) begin
            e.fl = 6'b000010; e.fmt = 3'd5;
        end else if (op == 7'b1101111) begin
            e.fl = 6'b000001; e.fmt = 3'd6;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Drive one cycle, push its expectation, then pop and compare after the edge.
    task automatic step(input logic r, input logic v, input logic [6:0] op, input string tag);
        exp_t obs, e;
        rst      = r;
        in_valid = v;
        opcode   = op;
        sb.push_back(r ? exp_t'('0) : model(v, op));
        @(posedge clk);
        #1;
        obs = {out_valid, R, I, S, B, U, J, illegal, fmt};
        e   = sb.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s op=%b obs=%b expected=%b", tag, op, obs, e);
        end
    endtask

    task automatic check_onehot(input string tag);
        tests++;
        assert ($countones({R, I, S, B, U, J}) <= 1) else begin
            fails++;
            $error("FAIL %s flags=%b expected at most one set", tag, {R, I, S, B, U, J});
        end
    endtask

`ifdef IDT_STATS_EN
    task automatic check_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0d expected=%0d", tag, obs, exp);
        end
    endtask
`endif

    logic [6:0] sweep_ops [11];

    initial begin
        sweep_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                      7'b0001111, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                      7'b1101111};
        rst      = 1'b1;
        in_valid = 1'b1;
        opcode   = 7'b0110011;
`ifdef IDT_STATS_EN
        stats_clr = 1'b0;
`endif

        // Reset overrides a valid R opcode for two cycles.
        step(1'b1, 1'b1, 7'b0110011, "reset0");
        step(1'b1, 1'b1, 7'b0110011, "reset1");
`ifdef IDT_STATS_EN
        check_cnt("reset_cnt_r", cnt_r, '0);
        check_cnt("reset_cnt_ill", cnt_ill, '0);
`endif

        // Sweep all supported opcodes back-to-back.
        for (int k = 0; k < 11; k++) begin
            step(1'b0, 1'b1, sweep_ops[k], "sweep");
        end

        // Illegal opcodes, including bits[1:0] != 11.
        step(1'b0, 1'b1, 7'b0000000, "illegal_00");
        step(1'b0, 1'b1, 7'b1111111, "illegal_7f");
        step(1'b0, 1'b1, 7'b0110001, "illegal_31");

        // Valid gating: a store opcode without in_valid must not show up.
        step(1'b0, 1'b1, 7'b0100011, "pre_gate_store");
        step(1'b0, 1'b0, 7'b0100011, "gate_store");
        step(1'b0, 1'b0, 7'b1101111, "gate_jal");

        // Exhaustive: every opcode back-to-back.
        for (int k = 0; k < 128; k++) begin
            step(1'b0, 1'b1, 7'(k), "exhaustive");
            check_onehot("onehot");
        end
        step(1'b0, 1'b0, 7'b0, "idle_after_exh");

`ifdef IDT_STATS_EN
        // Class counts: 3xR, 2xU, 1 illegal after a clear.
        stats_clr = 1'b1;
        step(1'b0, 1'b0, 7'b0, "clr");
        stats_clr = 1'b0;
        check_cnt("clr_cnt_i", cnt_i, '0);
        step(1'b0, 1'b1, 7'b0110011, "st_r");
        step(1'b0, 1'b1, 7'b0110011, "st_r");
        step(1'b0, 1'b1, 7'b0110011, "st_r");
        step(1'b0, 1'b1, 7'b0110111, "st_u");
        step(1'b0, 1'b1, 7'b0010111, "st_u");
        step(1'b0, 1'b1, 7'b0000000, "st_ill");
        check_cnt("cnt_r", cnt_r, 4'd3);
        check_cnt("cnt_u", cnt_u, 4'd2);
        check_cnt("cnt_ill", cnt_ill, 4'd1);
        check_cnt("cnt_i", cnt_i, 4'd0);
        check_cnt("cnt_j", cnt_j, 4'd0);
        check_cnt("cnt_s", cnt_s, 4'd0);
        check_cnt("cnt_b", cnt_b, 4'd0);

        // Clear has priority over a same-cycle increment.
        stats_clr = 1'b1;
        step(1'b0, 1'b1, 7'b0110011, "clr_with_r");
        stats_clr = 1'b0;
        check_cnt("clr_prio_cnt_r", cnt_r, 4'd0);
        check_cnt("clr_prio_cnt_u", cnt_u, 4'd0);

        // Saturation: 18 J opcodes into a 4-bit counter stay at 15.
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 1'b1, 7'b1101111, "sat_j");
        end
        check_cnt("sat_cnt_j", cnt_j, 4'hF);
        check_cnt("sat_cnt_r", cnt_r, 4'd0);
`endif

        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain left=%0d expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_idt
